// File: rtl/i2s_transmitter.sv
// i2s_transmitter: sample-pair FIFO feeding a Philips I2S serializer (16-bit stereo,
// MSB first, one BCLK delay after LRCK) plus a free-running codec master clock.
module i2s_transmitter #(
  parameter int BCLK_HALF  = 16,
  parameter int XCK_HALF   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [15:0]                 s_left,
  input  logic [15:0]                 s_right,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        underrun,
  output logic                        aud_xck,
  output logic                        aud_bclk,
  output logic                        aud_daclrck,
  output logic                        aud_dacdat
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int XW = $clog2(XCK_HALF + 1);
  localparam int BW = $clog2(BCLK_HALF + 1);
  localparam logic [XW-1:0] XCK_LAST   = XW'(XCK_HALF - 1);
  localparam logic [BW-1:0] BCLK_LAST  = BW'(BCLK_HALF - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [XW-1:0] xck_cnt_q, xck_cnt_d;
  logic [BW-1:0] bclk_cnt_q, bclk_cnt_d;
  logic          xck_q, xck_d, bclk_q, bclk_d;
  logic [4:0]    bit_q, bit_d;
  logic [31:0]   shift_q, shift_d;
  logic          lrck_q, lrck_d, dat_q, dat_d, und_q, und_d, ready_q, ready_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          bclk_wrap_s, fall_s, load_s, empty_s, push_s, pop_s;
  logic [31:0]   frame_s;

  // Next-state logic for clock dividers, serializer and FIFO bookkeeping.
  always_comb begin
    bclk_wrap_s = (bclk_cnt_q == BCLK_LAST);
    fall_s      = bclk_wrap_s && bclk_q;
    load_s      = fall_s && (bit_q == 5'd1);
    empty_s     = (count_q == {CW{1'b0}});
    // ready_q reflects the pre-pop fullness, so a push never meets a pop at full.
    push_s      = s_valid && ready_q;
    pop_s       = load_s && !empty_s;
    frame_s     = empty_s ? 32'h0000_0000 : mem_q[rd_ptr_q];

    xck_cnt_d  = (xck_cnt_q == XCK_LAST) ? {XW{1'b0}} : xck_cnt_q + XW'(1);
    xck_d      = (xck_cnt_q == XCK_LAST) ? ~xck_q : xck_q;
    bclk_cnt_d = bclk_wrap_s ? {BW{1'b0}} : bclk_cnt_q + BW'(1);
    bclk_d     = bclk_wrap_s ? ~bclk_q : bclk_q;

    bit_d   = bit_q;
    shift_d = shift_q;
    lrck_d  = lrck_q;
    dat_d   = dat_q;
    if (fall_s) begin
      bit_d  = bit_q + 5'd1;
      lrck_d = (bit_q >= 5'd16);
      if (load_s) begin
        dat_d   = frame_s[31];
        shift_d = {frame_s[30:0], 1'b0};
      end else begin
        dat_d   = shift_q[31];
        shift_d = {shift_q[30:0], 1'b0};
      end
    end else begin
      bit_d = bit_q;
    end
    und_d = load_s && empty_s;

    wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != FULL_COUNT);
  end

  // State registers with synchronous reset; a mid-frame reset simply abandons the frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      xck_cnt_q  <= {XW{1'b0}};
      bclk_cnt_q <= {BW{1'b0}};
      xck_q      <= 1'b0;
      bclk_q     <= 1'b0;
      bit_q      <= 5'd0;
      shift_q    <= 32'h0000_0000;
      lrck_q     <= 1'b0;
      dat_q      <= 1'b0;
      und_q      <= 1'b0;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      ready_q    <= 1'b1;
    end else begin
      xck_cnt_q  <= xck_cnt_d;
      bclk_cnt_q <= bclk_cnt_d;
      xck_q      <= xck_d;
      bclk_q     <= bclk_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      lrck_q     <= lrck_d;
      dat_q      <= dat_d;
      und_q      <= und_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
    end
  end

  // FIFO storage; contents are don't-care once the pointers reset.
  always_ff @(posedge clock) begin
    if (push_s && !reset) begin
      mem_q[wr_ptr_q] <= {s_left, s_right};
    end
  end

  assign s_ready     = ready_q;
  assign fifo_count  = count_q;
  assign underrun    = und_q;
  assign aud_xck     = xck_q;
  assign aud_bclk    = bclk_q;
  assign aud_daclrck = lrck_q;
  assign aud_dacdat  = dat_q;
endmodule

// File: tb/tb_i2s_transmitter.sv
// Randomized and directed bench for i2s_transmitter: a time-indexed reference model
// predicts every pin each cycle, and a bench-side I2S receiver checks decoded frames.
module tb_i2s_transmitter;
  localparam int BH    = 16;
  localparam int XH    = 2;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset, s_valid, s_ready, underrun;
  logic [15:0] s_left, s_right;
  logic [2:0]  fifo_count;
  logic        aud_xck, aud_bclk, aud_daclrck, aud_dacdat;

  always #5 clock = ~clock;

  i2s_transmitter #(.BCLK_HALF(BH), .XCK_HALF(XH), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right), .fifo_count(fifo_count), .underrun(underrun),
    .aud_xck(aud_xck), .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck), .aud_dacdat(aud_dacdat)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned t_m = 0;
  logic [31:0] q_m[$];
  logic [31:0] rx_exp[$];
  logic [31:0] cur_f_m, rx_sr;
  logic        lrck_m, dat_m, und_m, rx_bclk_prev, rx_lrck_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t_m);
    end
  endtask

  // Reference: pins are a function of clocks since reset; frame n's word drives bits by index.
  task automatic model_edge();
    int  n, k;
    bit  ready_before;
    ready_before = (q_m.size() < DEPTH);
    und_m = 1'b0;
    if (reset) begin
      t_m = 0; q_m.delete(); rx_exp.delete();
      cur_f_m = 32'd0; lrck_m = 1'b0; dat_m = 1'b0;
      rx_sr = 32'd0; rx_bclk_prev = 1'b0; rx_lrck_prev = 1'b0;
    end else begin
      t_m++;
      if (t_m % (2 * BH) == 0) begin
        n = int'(t_m / (2 * BH)) - 1;
        k = n % 32;
        lrck_m = (k >= 16);
        if (k == 1) begin
          if (q_m.size() > 0) begin
            cur_f_m = q_m.pop_front();
          end else begin
            cur_f_m = 32'd0;
            und_m   = 1'b1;
          end
          rx_exp.push_back(cur_f_m);
        end
        dat_m = (k == 0) ? cur_f_m[0] : cur_f_m[32 - k];
      end
      if (s_valid && ready_before) q_m.push_back({s_left, s_right});
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("xck", 32'(aud_xck), (t_m / XH) % 2);
    check("bclk", 32'(aud_bclk), (t_m / BH) % 2);
    check("lrck", 32'(aud_daclrck), 32'(lrck_m));
    check("dacdat", 32'(aud_dacdat), 32'(dat_m));
    check("underrun", 32'(underrun), 32'(und_m));
    check("fifo_count", 32'(fifo_count), 32'(q_m.size()));
    check("s_ready", 32'(s_ready), 32'(q_m.size() < DEPTH));
    if (!reset && !rx_bclk_prev && aud_bclk) begin
      rx_sr = {rx_sr[30:0], aud_dacdat};
      if (rx_lrck_prev && !aud_daclrck) begin
        check("rx_pending", 32'(rx_exp.size() > 0), 32'd1);
        if (rx_exp.size() > 0) check("rx_frame", rx_sr, rx_exp.pop_front());
      end
      rx_lrck_prev = aud_daclrck;
    end
    rx_bclk_prev = aud_bclk;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic push_one(input logic [15:0] l, input logic [15:0] r);
    bit accepted, rdy;
    int guard;
    accepted = 1'b0; guard = 0;
    s_left = l; s_right = r; s_valid = 1'b1;
    while (!accepted && guard < 5000) begin
      rdy = (q_m.size() < DEPTH);
      step();
      accepted = rdy;
      guard++;
    end
    s_valid = 1'b0;
    check("push_accept", 32'(accepted), 32'd1);
  endtask

  task automatic wait_t(input int unsigned target);
    int guard;
    guard = 0;
    while (t_m != target && guard < 5000) begin
      step();
      guard++;
    end
    check("wait_t", t_m, target);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  initial begin
    bit          rdy;
    logic [15:0] inc;
    reset = 1'b1; s_valid = 1'b0; s_left = 16'd0; s_right = 16'd0;
    do_reset(2);
    idle(2100);

    push_one(16'hA5C3, 16'h5A3C);
    idle(2100);
    push_one(16'h8000, 16'h7FFF);
    idle(2100);

    // Saturating producer with an incrementing pattern.
    inc = 16'h0001;
    s_left = inc; s_right = ~inc; s_valid = 1'b1;
    repeat (6200) begin
      rdy = (q_m.size() < DEPTH);
      step();
      if (rdy) begin
        inc = inc + 16'd1;
        s_left = inc; s_right = ~inc;
      end
    end
    s_valid = 1'b0;
    idle(4200);

    // Reset at k=20 with three entries queued.
    do_reset(1);
    for (int i = 0; i < 4; i++) push_one(16'(16'h1000 + i), 16'(16'h2000 + i));
    wait_t(32'd677);
    check("pre_reset_count", 32'(fifo_count), 32'd3);
    do_reset(1);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd1);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_pins", {28'd0, aud_xck, aud_bclk, aud_daclrck, aud_dacdat}, 32'd0);
    idle(1100);

    // Push coincident with the pop at fifo_count = 2.
    do_reset(1);
    push_one(16'h1111, 16'h2222);
    push_one(16'h3333, 16'h4444);
    wait_t(32'd63);
    s_left = 16'h5555; s_right = 16'h6666; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    check("simul_count", 32'(fifo_count), 32'd2);
    idle(4200);

    // Random sparse traffic.
    repeat (8000) begin
      if (!s_valid && $urandom_range(0, 39) == 0) begin
        s_valid = 1'b1;
        s_left = 16'($urandom); s_right = 16'($urandom);
      end
      rdy = (q_m.size() < DEPTH);
      step();
      if (s_valid && rdy) s_valid = 1'b0;
    end
    s_valid = 1'b0;
    idle(2100);

    check("rx_drain", 32'(rx_exp.size() <= 1), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- Audio output serializer inside the Falcon5 audio block; drives the WM8731 codec pins AUD_XCK, AUD_BCLK, AUD_DACLRCK and AUD_DACDAT.
- Accepts 16-bit signed stereo sample pairs from the audio sample sequencer over a valid/ready handshake into a small FIFO.
- Emits a continuous Philips I2S stream: 16 bits per channel, MSB first, one BCLK delay after each LRCK edge.
- Downstream consumer is the codec on the board, and the i2s_receiver model in simulation.

Parameters:
- BCLK_HALF, 16, clock cycles per BCLK half-period (50 MHz / 32 = 1.5625 MHz BCLK, 48.83 kHz frame rate).
- XCK_HALF, 2, clock cycles per AUD_XCK half-period (12.5 MHz MCLK).
- FIFO_DEPTH, 4, sample-pair FIFO entries; power of 2, minimum 2.

Ports:
- clock, in, 1, system clock (50 MHz).
- reset, in, 1, synchronous active-high reset.
- s_valid, in, 1, producer has a sample pair.
- s_ready, out, 1, FIFO not full; a transfer occurs when s_valid && s_ready.
- s_left, in, 16, signed left sample.
- s_right, in, 16, signed right sample.
- fifo_count, out, $clog2(FIFO_DEPTH)+1, entries currently held.
- underrun, out, 1, one-cycle pulse when a frame starts with the FIFO empty.
- aud_xck, out, 1, codec master clock.
- aud_bclk, out, 1, bit clock.
- aud_daclrck, out, 1, word select: 0 = left, 1 = right.
- aud_dacdat, out, 1, serial data.

Behaviour:
- All outputs are registered. Reset is synchronous: the FIFO empties, the dividers, frame counter and shift register clear, and all outputs go 0 except s_ready = 1 and fifo_count = 0. Reset asserted mid-frame aborts the frame immediately; no partial pop and no underrun pulse occur.
- XCK divider: the counter counts 0..XCK_HALF-1 and aud_xck toggles on wrap. It is free-running and independent of BCLK.
- BCLK divider: the counter counts 0..BCLK_HALF-1 and aud_bclk toggles on wrap. After reset the first toggle is rising, BCLK_HALF cycles after reset deasserts.
- Bit counter k (5 bits, 0..31) advances on each BCLK falling edge (the cycle aud_bclk goes 1->0). The first falling edge after reset is k=0, and k wraps 31->0.
- All pin updates (lrck, dacdat) occur in the same cycle as the BCLK falling edge, so they are stable at the rising edge.
- aud_daclrck after falling edge k equals (k >= 16).
- Frame word F = {L[15:0], R[15:0]}. On the falling edge with k == 1, F is loaded and aud_dacdat = F[31], the left MSB. On edges k = 2..31, aud_dacdat = F[32-k]; k = 16 carries the left LSB and k = 17 the right MSB. On edge k = 0 of the next frame, aud_dacdat = F[0], the right LSB of the previous frame. The first k = 0 after reset outputs 0.
- Pop: the head pair is popped in the k == 1 load cycle. If the FIFO is empty, F = 0 (silence) and underrun pulses high for exactly that cycle.
- Push: on s_valid && s_ready the pair is written at the tail.
- Simultaneous push and pop in one cycle: fifo_count is unchanged. This is legal when the FIFO is full because s_ready = !full is evaluated before the pop, so push and pop never coincide at full. A push to an empty FIFO in the same cycle as a pop does not satisfy that pop; it becomes the head for the next frame.
- fifo_count is in 0..FIFO_DEPTH, with pointer wrap modulo FIFO_DEPTH.
- Samples are passed through bit-exact: no scaling, dithering or sign handling.

Test Plan:
- Reset, then idle with no samples -> aud_bclk period 32 clocks, aud_daclrck period 1024 clocks (low 512, high 512), aud_xck period 4 clocks. underrun pulses once per frame and aud_dacdat stays 0.
- Push one pair L=16'hA5C3, R=16'h5A3C before the second frame's k=1 -> i2s_receiver reports left_sample = 16'hA5C3 and right_sample = 16'h5A3C with sample_valid. That frame has no underrun pulse.
- Push L=16'h8000, R=16'h7FFF -> MSB of the left word appears one BCLK after aud_daclrck falls. The right LSB (1) appears on the k=0 edge after aud_daclrck rises back.
- Hold s_valid high with an incrementing pattern -> s_ready drops after 4 accepts and fifo_count = 4. Exactly one accept follows each frame pop, and the received sequence has no gaps or duplicates.
- Assert reset for 1 cycle at k=20 of a frame with fifo_count = 3 -> the next cycle has all pins 0, fifo_count = 0 and s_ready = 1, with no underrun pulse. The stream restarts with the first rising BCLK 16 cycles later.
- Push and pop in the same cycle at fifo_count = 2 -> fifo_count remains 2 and data order is preserved.
